// File: rtl/fpm_arbiter.sv
// Round-robin arbiter/sequencer sharing one fp_mult among NREQ requesters.
// Optional RUN-phase abort is compiled in with `define FPM_TIMEOUT_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op outstanding; grant the next requester round-robin
// LOAD  | fp_mult held in reset for one cycle to clear a stale done
// RUN   | fp_mult enabled; wait for done (or timeout abort)
module fpm_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   a_in,
  input  logic [NREQ*32-1:0]   b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      res_valid,
  output logic [31:0]          res_z,
  output logic                 err,
  output logic                 busy,
  output logic [15:0]          ops_count,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_en,
  output logic                 mul_rst,
  input  logic                 mul_done,
  input  logic [31:0]          mul_z
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN = 32'hFFC00000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            win_found;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] owner_oh;
  logic            tmo_hit;

`ifdef FPM_TIMEOUT_EN
  logic [15:0] run_cnt;

  // Counts elapsed RUN cycles; cleared while in LOAD so it starts at 0 in RUN.
  always_ff @(posedge clk) begin
    if (!rst)
      run_cnt <= '0;
    else if (state == S_LOAD)
      run_cnt <= '0;
    else if (state == S_RUN && !mul_done)
      run_cnt <= run_cnt + 16'd1;
  end

  assign tmo_hit = (state == S_RUN) && !mul_done && (run_cnt == 16'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit = 1'b0;
`endif

  // Rotating priority search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_found) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_RUN;
      S_RUN:   if (mul_done || tmo_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        a_sel = a_in[32*i +: 32];
        b_sel = b_in[32*i +: 32];
      end
    end
    win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt       <= '0;
      res_valid <= '0;
      res_z     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ops_count <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_en    <= 1'b0;
      mul_rst   <= 1'b0;
      ptr       <= IW'(NREQ - 1);
      owner     <= '0;
    end else begin
      gnt       <= '0;
      res_valid <= '0;
      err       <= 1'b0;
      busy      <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt     <= win_oh;
            mul_a   <= a_sel;
            mul_b   <= b_sel;
            ptr     <= win_idx;
            owner   <= win_idx;
            mul_rst <= 1'b1;
          end
        end
        S_LOAD: begin
          mul_rst <= 1'b0;
          mul_en  <= 1'b1;
        end
        S_RUN: begin
          // A done arriving on the timeout edge takes priority over the abort.
          if (mul_done) begin
            res_z     <= mul_z;
            res_valid <= owner_oh;
            mul_en    <= 1'b0;
            ops_count <= ops_count + 16'd1;
          end else if (tmo_hit) begin
            res_z     <= QNAN;
            res_valid <= owner_oh;
            err       <= 1'b1;
            mul_en    <= 1'b0;
            ops_count <= ops_count + 16'd1;
          end
        end
        default: begin
          mul_en  <= 1'b0;
          mul_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_arbiter.sv
// Directed bench for fpm_arbiter with a fixed-latency fp_mult stand-in.
// Build with +define+FPM_TIMEOUT_EN to also exercise the timeout abort.
module tb_fpm_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] a_in;
  logic [NREQ*32-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   res_valid;
  logic [31:0]       res_z;
  logic              err;
  logic              busy;
  logic [15:0]       ops_count;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_en;
  logic              mul_rst;
  logic              mul_done;
  logic [31:0]       mul_z;

  always #5 clk = ~clk;

  fpm_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_valid(res_valid), .res_z(res_z), .err(err), .busy(busy),
    .ops_count(ops_count), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .mul_rst(mul_rst), .mul_done(mul_done), .mul_z(mul_z)
  );

  // Hand-computed products for the operand pairs used below.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40400000, 32'h41200000}: prod = 32'h41F00000;
      {32'h3F800000, 32'h3E800000}: prod = 32'h3E800000;
      {32'h3EA00000, 32'h3F600000}: prod = 32'h3E8C0000;
      {32'h3E800000, 32'h00000000}: prod = 32'h00000000;
      {32'h7F800000, 32'h00000000}: prod = 32'hFFC00000;
      default:                      prod = 32'hDEADBEEF;
    endcase
  endfunction

  // fp_mult stand-in: done is sticky until the next mul_rst.
  logic        done_r    = 1'b0;
  logic [31:0] z_r       = 32'h0;
  int          mcnt      = 0;
  logic        kill_done = 1'b0;
  assign mul_done = done_r & ~kill_done;
  assign mul_z    = z_r;

  always @(posedge clk) begin
    if (mul_rst) begin
      done_r <= 1'b0;
      mcnt   <= 0;
    end else if (mul_en && !done_r) begin
      if (mcnt == LAT - 1) begin
        done_r <= 1'b1;
        z_r    <= prod(mul_a, mul_b);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh2i(input logic [NREQ-1:0] v);
    oh2i = 99;
    if ($countones(v) == 1)
      for (int i = 0; i < NREQ; i++) if (v[i]) oh2i = i;
  endfunction

  int          gnt_q[$];
  int          gnt_cyc[$];
  int          res_idx[$];
  int          res_cyc[$];
  logic [31:0] res_zq[$];

  always @(negedge clk) begin
    if (gnt != '0) begin
      gnt_q.push_back(oh2i(gnt));
      gnt_cyc.push_back(cyc);
    end
    if (res_valid != '0) begin
      res_idx.push_back(oh2i(res_valid));
      res_cyc.push_back(cyc);
      res_zq.push_back(res_z);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_res(input int budget, output int ncyc);
    ncyc = 0;
    while (res_valid == '0 && ncyc < budget) begin
      @(negedge clk);
      ncyc++;
    end
    if (res_valid == '0) chk("wait_res", {31'b0, |res_valid}, 32'd1);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    a_in[32*i +: 32] = a;
    b_in[32*i +: 32] = b;
  endtask

  int n;
  int seen;
  int exp_gnt[5];
  logic [31:0] exp_z[5];

  initial begin
    rst  = 1'b0;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);

    chk("rst_gnt",       32'(gnt), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_z",     res_z, 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_ops",       32'(ops_count), 32'd0);
    chk("rst_mul_ab",    mul_a | mul_b, 32'd0);
    chk("rst_mul_ctl",   {30'b0, mul_en, mul_rst}, 32'd0);

    // Single request from requester 0.
    set_ops(0, 32'h40400000, 32'h41200000);
    rst = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt",     32'(gnt), 32'h1);
    chk("t1_mul_rst", 32'(mul_rst), 32'd1);
    chk("t1_mul_a",   mul_a, 32'h40400000);
    chk("t1_mul_b",   mul_b, 32'h41200000);
    req = '0;
    @(negedge clk);
    chk("t1_load",    {29'b0, |gnt, mul_rst, mul_en}, 32'b001);
    wait_res(30, n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_valid",   32'(res_valid), 32'h1);
    chk("t1_res_z",   res_z, 32'h41F00000);
    chk("t1_ops",     32'(ops_count), 32'd1);
    chk("t1_err",     32'(err), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_idle",    {30'b0, busy, |res_valid}, 32'd0);
    chk("t1_hold_z",  res_z, 32'h41F00000);

    // All four requesters held high from reset.
    rst = 1'b0;
    req = 4'b1111;
    set_ops(1, 32'h3F800000, 32'h3E800000);
    set_ops(2, 32'h3EA00000, 32'h3F600000);
    set_ops(3, 32'h3E800000, 32'h00000000);
    repeat (2) @(negedge clk);
    gnt_q.delete(); gnt_cyc.delete();
    res_idx.delete(); res_cyc.delete(); res_zq.delete();
    rst = 1'b1;
    n = 0;
    while (gnt_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req = '0;
    n = 0;
    while (res_zq.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("t2_ngrants", 32'(gnt_q.size()), 32'd5);
    chk("t2_nres",    32'(res_zq.size()), 32'd5);
    exp_gnt = '{0, 1, 2, 3, 0};
    exp_z   = '{32'h41F00000, 32'h3E800000, 32'h3E8C0000, 32'h00000000, 32'h41F00000};
    seen = (gnt_q.size() < 5 || res_zq.size() < 5) ? 0 : 5;
    for (int i = 0; i < seen; i++) begin
      chk($sformatf("t2_gnt%0d", i),  32'(gnt_q[i]), 32'(exp_gnt[i]));
      chk($sformatf("t2_ridx%0d", i), 32'(res_idx[i]), 32'(exp_gnt[i]));
      chk($sformatf("t2_z%0d", i),    res_zq[i], exp_z[i]);
      if (i < 4) chk($sformatf("t2_gap%0d", i), 32'(gnt_cyc[i+1] - res_cyc[i]), 32'd1);
    end
    chk("t2_ops", 32'(ops_count), 32'd5);

    // Inf * 0 pair through requester 1.
    set_ops(1, 32'h7F800000, 32'h00000000);
    req = 4'b0010;
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_res(30, n);
    chk("t3_valid", 32'(res_valid), 32'h2);
    chk("t3_res_z", res_z, 32'hFFC00000);
    chk("t3_err",   32'(err), 32'd0);

    // Reset while RUN is in progress.
    set_ops(3, 32'h3F800000, 32'h3E800000);
    req = 4'b1000;
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h8);
    req = '0;
    repeat (2) @(negedge clk);
    chk("t4_in_run", 32'(mul_en), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_pulses", {24'b0, gnt, res_valid}, 32'd0);
    chk("t4_rst_flags",  {28'b0, err, busy, mul_en, mul_rst}, 32'd0);
    chk("t4_rst_ops",    32'(ops_count), 32'd0);
    chk("t4_rst_z",      res_z, 32'd0);
    chk("t4_rst_mul_ab", mul_a | mul_b, 32'd0);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid != '0) seen++;
    end
    chk("t4_no_valid", 32'(seen), 32'd0);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_gnt2", 32'(gnt), 32'h4);
    req = '0;
    wait_res(30, n);
    chk("t4_res_z2", res_z, 32'h3E8C0000);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    chk("t4_ptr_reset", 32'(gnt), 32'h1);
    req = '0;
    wait_res(30, n);
    chk("t4_ops", 32'(ops_count), 32'd1);

`ifdef FPM_TIMEOUT_EN
    kill_done = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h1);
    req = '0;
    wait_res(40, n);
    chk("t5_latency", 32'(n), 32'd9);
    chk("t5_valid",   32'(res_valid), 32'h1);
    chk("t5_err",     32'(err), 32'd1);
    chk("t5_res_z",   res_z, 32'hFFC00000);
    @(negedge clk);
    chk("t5_after",   {30'b0, busy, err}, 32'd0);
    kill_done = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
